// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: Caddr encodings,
// microword field positions, opcode constants, microprogram addresses
// and the control-store image.
package useq_pkg;

  // Microword geometry
  localparam int MW_W           = 15;
  localparam int MW_PCWR        = 14;
  localparam int MW_PCWRCOND    = 13;
  localparam int MW_IORD        = 12;
  localparam int MW_MEMRD       = 11;
  localparam int MW_TRANSIN_HI  = 10;
  localparam int MW_TRANSIN_LO  = 8;
  localparam int MW_ALUOP_HI    = 7;
  localparam int MW_ALUOP_LO    = 6;
  localparam int MW_ALUSRCB_HI  = 5;
  localparam int MW_ALUSRCB_LO  = 4;
  localparam int MW_ALUSRCA     = 3;
  localparam int MW_REGWR       = 2;
  localparam int MW_CADDR_HI    = 1;
  localparam int MW_CADDR_LO    = 0;

  typedef logic [MW_W-1:0] microword_t;

  // Next-address selector carried in the low two bits of every microword
  typedef enum logic [1:0] {
    CA_SEQ   = 2'b00,
    CA_DISP1 = 2'b01,
    CA_DISP2 = 2'b10,
    CA_FETCH = 2'b11
  } caddr_e;

  // Opcodes recognised by the dispatch tables (instruction bits [31:26])
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  // Fixed microprogram entry points
  localparam int unsigned ADDR_FETCH   = 0;
  localparam int unsigned ADDR_DECODE  = 1;
  localparam int unsigned ADDR_MEMADDR = 2;
  localparam int unsigned ADDR_LWREAD  = 3;
  localparam int unsigned ADDR_LWWB    = 4;
  localparam int unsigned ADDR_REXEC   = 5;
  localparam int unsigned ADDR_RWB     = 6;
  localparam int unsigned ADDR_BEQ     = 7;
  localparam int unsigned ADDR_JUMP    = 8;

  localparam int unsigned ROM_DEPTH    = 16;

  // Assemble a microword from its fields, most significant field first
  function automatic microword_t mw(input logic       pcWr,
                                    input logic       pcWrCond,
                                    input logic       iorD,
                                    input logic       memRd,
                                    input logic [2:0] transIn,
                                    input logic [1:0] aluOp,
                                    input logic [1:0] aluSrcB,
                                    input logic       aluSrcA,
                                    input logic       regWr,
                                    input caddr_e     caddr);
    return {pcWr, pcWrCond, iorD, memRd, transIn, aluOp, aluSrcB,
            aluSrcA, regWr, caddr};
  endfunction

  // Spare locations repeat the fetch word but return to fetch, so a stray
  // jump into unused space still lands on a sane instruction boundary.
  localparam microword_t MW_SPARE = mw(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 2'b00,
                                       2'b01, 1'b0, 1'b0, CA_FETCH);

  // Control store image, indexed by micro-address
  localparam microword_t ROM_IMAGE [ROM_DEPTH] = '{
    // 0 fetch: IR <= Mem[PC], PC <= PC+4
    mw(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 2'b00, 2'b01, 1'b0, 1'b0, CA_SEQ),
    // 1 decode: ALUOut <= PC + (sext(imm) << 2)
    mw(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b11, 1'b0, 1'b0, CA_DISP1),
    // 2 mem-addr: ALUOut <= A + sext(imm)
    mw(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b10, 1'b1, 1'b0, CA_DISP2),
    // 3 lw read: MDR <= Mem[ALUOut]
    mw(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, CA_SEQ),
    // 4 lw writeback: Reg[rt] <= MDR
    mw(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 2'b00, 2'b00, 1'b0, 1'b1, CA_FETCH),
    // 5 R-exec: ALUOut <= A funct B
    mw(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 2'b00, 1'b1, 1'b0, CA_SEQ),
    // 6 R-writeback: Reg[rd] <= ALUOut
    mw(1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 2'b00, 2'b00, 1'b0, 1'b1, CA_FETCH),
    // 7 beq: if (A == B) PC <= ALUOut
    mw(1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 2'b01, 2'b00, 1'b1, 1'b0, CA_FETCH),
    // 8 jump: PC <= {PC[31:28], target, 2'b00}
    mw(1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0, CA_FETCH),
    // 9..15 spare
    MW_SPARE, MW_SPARE, MW_SPARE, MW_SPARE, MW_SPARE, MW_SPARE, MW_SPARE
  };

  // Control-store read; addresses beyond the image behave like spare words
  function automatic microword_t romWord(input int unsigned addr);
    microword_t word;
    if (addr < ROM_DEPTH) word = ROM_IMAGE[addr[3:0]];
    else                  word = MW_SPARE;
    return word;
  endfunction

endpackage

// File: rtl/useq_dispatch.sv
// Opcode dispatch lookup for the microprogram sequencer. Purely
// combinational: the current Caddr picks DISPATCH1 or DISPATCH2, and the
// miss flag marks an opcode the selected table does not map.
module useq_dispatch
  import useq_pkg::*;
#(
  parameter int UPC_W = 4,
  parameter int OP_W  = 6
) (
  input  logic [OP_W-1:0]  opcode,
  input  caddr_e           caddr,
  output logic [UPC_W-1:0] dispAddr,
  output logic             dispMiss
);

  // Table lookup; unmapped opcodes point at fetch and raise the miss flag
  always_comb begin
    dispAddr = UPC_W'(ADDR_FETCH);
    dispMiss = 1'b0;
    case (caddr)
      CA_DISP1: begin
        if (opcode == OP_W'(OP_R))        dispAddr = UPC_W'(ADDR_REXEC);
        else if (opcode == OP_W'(OP_LW))  dispAddr = UPC_W'(ADDR_MEMADDR);
        else if (opcode == OP_W'(OP_BEQ)) dispAddr = UPC_W'(ADDR_BEQ);
        else if (opcode == OP_W'(OP_J))   dispAddr = UPC_W'(ADDR_JUMP);
        else                              dispMiss = 1'b1;
      end
      CA_DISP2: begin
        if (opcode == OP_W'(OP_LW))       dispAddr = UPC_W'(ADDR_LWREAD);
        else                              dispMiss = 1'b1;
      end
      default: begin
        dispAddr = UPC_W'(ADDR_FETCH);
        dispMiss = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: micro-PC, control store and next-address
// selection. Drives the registered microword for the field decoder.
// Optional feature macro: USEQ_ILLEGAL_TRAP_EN adds a sticky `illegal`
// output raised when a dispatch finds an unmapped opcode.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int UPC_W = 4,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic             stall,
  output logic [MW_W-1:0]  micro_ir,
  output logic [UPC_W-1:0] upc,
  output logic             instr_done
`ifdef USEQ_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  caddr_e           caddr;
  logic [UPC_W-1:0] dispAddr;
  logic             dispMiss;
  logic [UPC_W-1:0] nextUpc;

  assign caddr = caddr_e'(micro_ir[MW_CADDR_HI:MW_CADDR_LO]);

  useq_dispatch #(
    .UPC_W (UPC_W),
    .OP_W  (OP_W)
  ) uDispatch (
    .opcode   (opcode),
    .caddr    (caddr),
    .dispAddr (dispAddr),
    .dispMiss (dispMiss)
  );

  // Next micro-address from the current word's Caddr field
  always_comb begin
    nextUpc = UPC_W'(ADDR_FETCH);
    case (caddr)
      CA_SEQ:             nextUpc = upc + UPC_W'(1);
      CA_DISP1, CA_DISP2: nextUpc = dispMiss ? UPC_W'(ADDR_FETCH) : dispAddr;
      default:            nextUpc = UPC_W'(ADDR_FETCH);
    endcase
  end

  // ---- stage boundary: micro-PC / microword register ----
  // micro_ir is loaded from the same address as upc so it always mirrors
  // ROM[upc]; stall freezes both and suppresses the completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      upc        <= UPC_W'(ADDR_FETCH);
      micro_ir   <= romWord(ADDR_FETCH);
      instr_done <= 1'b0;
    end else if (stall) begin
      instr_done <= 1'b0;
    end else begin
      upc        <= nextUpc;
      micro_ir   <= romWord(32'(nextUpc));
      instr_done <= (caddr == CA_FETCH);
    end
  end

`ifdef USEQ_ILLEGAL_TRAP_EN
  // Sticky trap flag, set on the edge a missed dispatch returns to fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if (!stall && dispMiss) begin
      illegal <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer. Expected micro-address traces
// are derived per instruction class; microwords come from a local table.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [5:0]  opcode;
  logic [14:0] micro_ir;
  logic [3:0]  upc;
  logic        instr_done;
`ifdef USEQ_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int checks   = 0;
  int failures = 0;

  logic [14:0] romRef [16];
  bit          illegalModel;
  int          expPath[$];

  always #5 clk = ~clk;

  micro_sequencer #(
    .UPC_W (4),
    .OP_W  (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .stall      (stall),
    .micro_ir   (micro_ir),
    .upc        (upc),
    .instr_done (instr_done)
`ifdef USEQ_ILLEGAL_TRAP_EN
    ,
    .illegal    (illegal)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit isMapped(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) ||
           (op == 6'b000100) || (op == 6'b000010);
  endfunction

  // Addresses visited after fetch, per instruction class
  function automatic void buildPath(input logic [5:0] op);
    expPath = {};
    expPath.push_back(1);
    case (op)
      6'b000000: begin expPath.push_back(5); expPath.push_back(6); end
      6'b100011: begin expPath.push_back(2); expPath.push_back(3); expPath.push_back(4); end
      6'b000100: expPath.push_back(7);
      6'b000010: expPath.push_back(8);
      default:   ;
    endcase
  endfunction

  // Run one instruction from fetch back to fetch with optional random stalls
  task automatic runInstr(input logic [5:0] op, input int maxStall, input string tag);
    logic [3:0] cur;
    logic [3:0] nxt;
    logic       doneExp;
    int         nStall;
    opcode = op;
    buildPath(op);
    cur = 4'd0;
    checks++;
    if (upc !== 4'd0) begin
      failures++;
      $display("FAIL %s start upc got %0d want 0", tag, upc);
    end
    for (int k = 0; k <= expPath.size(); k++) begin
      nxt     = (k < expPath.size()) ? 4'(expPath[k]) : 4'd0;
      doneExp = (k == expPath.size()) && isMapped(op);
      nStall  = (maxStall > 0) ? int'($urandom_range(maxStall, 0)) : 0;
      for (int s = 0; s < nStall; s++) begin
        stall = 1'b1;
        step();
        checks++;
        if ({upc, micro_ir, instr_done} !== {cur, romRef[cur], 1'b0}) begin
          failures++;
          $display("FAIL %s stall hold upc=%0d ir=%h done=%b want upc=%0d ir=%h done=0",
                   tag, upc, micro_ir, instr_done, cur, romRef[cur]);
        end
      end
      stall = 1'b0;
      step();
      if (cur == 4'd1 && !isMapped(op)) illegalModel = 1'b1;
      checks++;
      if (upc !== nxt) begin
        failures++;
        $display("FAIL %s upc got %0d want %0d", tag, upc, nxt);
      end
      checks++;
      if (micro_ir !== romRef[nxt]) begin
        failures++;
        $display("FAIL %s micro_ir got %h want %h at upc %0d", tag, micro_ir, romRef[nxt], nxt);
      end
      checks++;
      if (instr_done !== doneExp) begin
        failures++;
        $display("FAIL %s instr_done got %b want %b at upc %0d", tag, instr_done, doneExp, nxt);
      end
`ifdef USEQ_ILLEGAL_TRAP_EN
      checks++;
      if (illegal !== illegalModel) begin
        failures++;
        $display("FAIL %s illegal got %b want %b", tag, illegal, illegalModel);
      end
`endif
      cur = nxt;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    stall  = 1'b0;
    opcode = 6'b000000;
    step();
    step();
    illegalModel = 1'b0;
    checks++;
    if (upc !== 4'd0) begin
      failures++;
      $display("FAIL reset upc got %0d want 0", upc);
    end
    checks++;
    if (micro_ir !== romRef[0]) begin
      failures++;
      $display("FAIL reset micro_ir got %h want %h", micro_ir, romRef[0]);
    end
    checks++;
    if (instr_done !== 1'b0) begin
      failures++;
      $display("FAIL reset instr_done got %b want 0", instr_done);
    end
`ifdef USEQ_ILLEGAL_TRAP_EN
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset illegal got %b want 0", illegal);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_instr_types();
    runInstr(6'b000000, 0, "rtype");
    runInstr(6'b100011, 0, "lw");
    runInstr(6'b000100, 0, "beq");
    runInstr(6'b000010, 0, "jump");
  endtask

  task automatic test_stall();
    logic [3:0] want [3];
    want = '{4'd1, 4'd2, 4'd3};
    opcode = 6'b100011;
    stall  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (upc !== want[k]) begin
        failures++;
        $display("FAIL stall lead-in upc got %0d want %0d", upc, want[k]);
      end
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({upc, micro_ir, instr_done} !== {4'd3, romRef[3], 1'b0}) begin
        failures++;
        $display("FAIL stall freeze upc=%0d ir=%h done=%b want upc=3 ir=%h done=0",
                 upc, micro_ir, instr_done, romRef[3]);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if ({upc, micro_ir} !== {4'd4, romRef[4]}) begin
      failures++;
      $display("FAIL stall release upc=%0d ir=%h want upc=4 ir=%h", upc, micro_ir, romRef[4]);
    end
    stall = 1'b1;
    step();
    checks++;
    if ({upc, instr_done} !== {4'd4, 1'b0}) begin
      failures++;
      $display("FAIL stall on writeback upc=%0d done=%b want upc=4 done=0", upc, instr_done);
    end
    stall = 1'b0;
    step();
    checks++;
    if ({upc, instr_done} !== {4'd0, 1'b1}) begin
      failures++;
      $display("FAIL stall finish upc=%0d done=%b want upc=0 done=1", upc, instr_done);
    end
  endtask

  task automatic test_illegal();
    runInstr(6'b111111, 0, "illegal_op");
    runInstr(6'b000000, 0, "after_illegal");
    runInstr(6'b100011, 1, "after_illegal_lw");
  endtask

  task automatic test_reset_mid();
    opcode = 6'b000000;
    stall  = 1'b0;
    step();
    step();
    checks++;
    if (upc !== 4'd5) begin
      failures++;
      $display("FAIL reset_mid setup upc got %0d want 5", upc);
    end
    rst   = 1'b1;
    stall = 1'b1;
    step();
    illegalModel = 1'b0;
    checks++;
    if ({upc, micro_ir, instr_done} !== {4'd0, romRef[0], 1'b0}) begin
      failures++;
      $display("FAIL reset_mid upc=%0d ir=%h done=%b want upc=0 ir=%h done=0",
               upc, micro_ir, instr_done, romRef[0]);
    end
`ifdef USEQ_ILLEGAL_TRAP_EN
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid illegal got %b want 0", illegal);
    end
`endif
    rst   = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    logic [5:0] legal [4];
    legal = '{6'b000000, 6'b100011, 6'b000100, 6'b000010};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(4, 0) == 0) op = 6'($urandom_range(63, 0));
      else                           op = legal[$urandom_range(3, 0)];
      runInstr(op, 2, "random");
    end
  endtask

  initial begin
    romRef = '{15'h4910, 15'h0031, 15'h002A, 15'h1800, 15'h0207, 15'h0088,
               15'h0307, 15'h244B, 15'h4503, 15'h4913, 15'h4913, 15'h4913,
               15'h4913, 15'h4913, 15'h4913, 15'h4913};
    illegalModel = 1'b0;
    rst    = 1'b1;
    stall  = 1'b0;
    opcode = 6'b000000;
    test_reset();
    test_instr_types();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
